// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared constants for the UART transmitter.
// Holds the board clock frequency and the 2-bit FSM state encodings.
package uart_tx_pkg;

    localparam int BOARD_CLK_FREQ = 100_000_000;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        START = ST_START,
        DATA  = ST_DATA,
        STOP  = ST_STOP
    } state_e;

endpackage

// File: rtl/uart_tx_baud_gen.sv
// baud_gen: bit-period counter, wraps CLKS_PER_BIT-1 -> 0 and flags the
// last cycle of each bit. Ports: clk, rst (async, active-low), clear, tick.
module baud_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a valid/ready byte input.
// Ports: clk, rst (async, active-low), tx_data, tx_valid, tx_ready, tx, busy.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = BOARD_CLK_FREQ,
    parameter int BAUD     = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    state_e     state_q;
    logic [7:0] shreg_q;
    logic [2:0] idx_q;
    logic       tx_q;
    logic       rdy_q;
    logic       tick;

    // The counter is held at zero while idle, so the acceptance edge
    // starts a fresh bit period for the start bit.
    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clear(rdy_q),
        .tick (tick)
    );

    assign tx       = tx_q;
    assign tx_ready = rdy_q;
    assign busy     = ~rdy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shreg_q <= 8'h00;
            idx_q   <= 3'd0;
            tx_q    <= 1'b1;
            rdy_q   <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        shreg_q <= tx_data;
                        idx_q   <= 3'd0;
                        tx_q    <= 1'b0;
                        rdy_q   <= 1'b0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx_q == 3'd7) begin
                            idx_q   <= 3'd0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            idx_q   <= idx_q + 3'd1;
                            tx_q    <= shreg_q[idx_q + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        rdy_q   <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: randomized bench for uart_tx with a frame-level line model
// and an independent mid-bit receiver that decodes every frame.
module tb_uart_tx;

    logic       clk;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx;
    logic       busy;

    int n_chk;
    int n_fail;

    uart_tx #(
        .CLK_FREQ(800),
        .BAUD    (100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx      (tx),
        .busy    (busy)
    );

    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // Line model: a frame accepted in cycle c occupies cycles
    // c+1 .. c+FRAME; the line is ready again from c+FRAME+1.
    int         cyc;
    bit         active;
    int         fstart;
    logic [7:0] fbyte;
    logic [7:0] acc_q[$];

    // Independent receiver state.
    bit         rx_on;
    int         rx_n;
    logic [7:0] rx_b;

    initial begin
        cyc    = 0;
        active = 0;
        fstart = 0;
        fbyte  = 8'h00;
        rx_on  = 0;
        rx_n   = 0;
        rx_b   = 8'h00;
    end

    always @(negedge clk) begin
        logic exp_tx;
        logic exp_rdy;
        int   pos;
        logic [7:0] got_b;
        if (!rst) begin
            active  = 0;
            exp_tx  = 1'b1;
            exp_rdy = 1'b1;
            acc_q.delete();
        end else begin
            exp_rdy = !active || (cyc >= fstart + FRAME);
            exp_tx  = 1'b1;
            if (active && cyc >= fstart && cyc < fstart + FRAME) begin
                pos = (cyc - fstart) / CPB;
                if (pos == 0)
                    exp_tx = 1'b0;
                else if (pos <= 8)
                    exp_tx = fbyte[pos-1];
            end
        end
        chk("tx", 32'(tx), 32'(exp_tx));
        chk("tx_ready", 32'(tx_ready), 32'(exp_rdy));
        chk("busy", 32'(busy), 32'(!exp_rdy));
        if (rst && tx_valid && exp_rdy) begin
            active = 1;
            fstart = cyc + 1;
            fbyte  = tx_data;
            acc_q.push_back(tx_data);
        end

        if (!rst) begin
            rx_on = 0;
        end else begin
            if (!rx_on && tx == 1'b0) begin
                rx_on = 1;
                rx_n  = 0;
            end
            if (rx_on) begin
                if (rx_n % CPB == CPB / 2) begin
                    pos = rx_n / CPB;
                    if (pos == 0) begin
                        chk("rx_start", 32'(tx), 32'(0));
                    end else if (pos <= 8) begin
                        rx_b[pos-1] = tx;
                    end else begin
                        chk("rx_stop", 32'(tx), 32'(1));
                        chk("rx_queued", 32'(acc_q.size() != 0), 32'(1));
                        if (acc_q.size() != 0) begin
                            got_b = acc_q.pop_front();
                            chk("rx_byte", 32'(rx_b), 32'(got_b));
                        end
                        rx_on = 0;
                    end
                end
                rx_n++;
            end
        end
        cyc++;
    end

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer a byte, wait for the handshake edge, return 1 cycle after it.
    task automatic send(input logic [7:0] b, input bit hold);
        int k;
        tx_data  = b;
        tx_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!tx_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200)
            chk("ready_timeout", 32'(0), 32'(1));
        @(posedge clk);
        #1;
        if (!hold)
            tx_valid = 1'b0;
    endtask

    task automatic pulse_busy(input int after);
        tick_n(after);
        tx_data  = 8'($urandom);
        tx_valid = 1'b1;
        tick_n(1);
        tx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        bit         hold;
        n_chk    = 0;
        n_fail   = 0;
        rst      = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tick_n(3);
        rst = 1'b1;
        tick_n(20);

        send(8'h55, 0);
        tick_n(90);

        send(8'hA3, 1);
        tx_data = 8'h0F;
        send(8'h0F, 0);
        tick_n(90);

        send(8'h00, 0);
        tick_n(20);
        tx_data = 8'hFF;
        tick_n(70);

        send(8'($urandom), 0);
        tick_n(43);
        rst = 1'b0;
        tick_n(2);
        rst = 1'b1;
        send(8'h81, 0);
        tick_n(90);

        send(8'($urandom), 0);
        pulse_busy(20);
        pulse_busy(30);
        tick_n(40);

        for (int i = 0; i < 25; i++) begin
            b    = 8'($urandom);
            hold = 1'($urandom % 2);
            send(b, hold);
            if (!hold && ($urandom % 3 == 0))
                pulse_busy(int'($urandom_range(2, 70)));
            tick_n(int'($urandom % 3));
        end
        tx_valid = 1'b0;
        tick_n(2 * FRAME + 10);
        chk("all_decoded", 32'(acc_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 100000000, meaning the system clock frequency in Hz (Nexys A7 board clock).
REQ-002 The block SHALL have parameter BAUD, default 115200, meaning the serial bit rate.
REQ-003 The block SHALL have localparam CLKS_PER_BIT = CLK_FREQ/BAUD (integer division), with a value of at least 2.
REQ-004 The block SHALL have the port clk  input  1  system clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have the port rst  input  1  reset, asynchronous, active-low.
REQ-006 The block SHALL have the port tx_data  input  8  byte to transmit, sampled only at acceptance.
REQ-007 The block SHALL have the port tx_valid  input  1  producer holds a byte for transmission.
REQ-008 The block SHALL have the port tx_ready  output  1  block can accept a byte this cycle.
REQ-009 The block SHALL have the port tx  output  1  serial line, idle high, driven from a flop.
REQ-010 The block SHALL have the port busy  output  1  a frame is in progress.

Function
REQ-011 Frame format SHALL be 8N1: one start bit (0), eight data bits LSB first, one stop bit (1).
REQ-012 The FSM SHALL have the states IDLE, START, DATA and STOP.
REQ-013 tx_ready SHALL be 1 only in IDLE; busy SHALL equal the inverse of tx_ready.
REQ-014 Acceptance SHALL occur at a rising edge where tx_valid=1 and tx_ready=1; at that edge, tx_data latches into the shift register, the FSM enters START, the baud counter clears and tx is set to 0.
REQ-015 tx SHALL go low in the first cycle after the acceptance edge (latency 1 cycle).
REQ-016 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, counted by a counter that wraps from CLKS_PER_BIT-1 to 0 and emits a bit-end tick.
REQ-017 On a START tick, the FSM SHALL enter DATA and tx SHALL be set to bit 0 of the shift register.
REQ-018 In DATA, a 3-bit index SHALL advance on each tick; after the bit-7 period, the FSM SHALL enter STOP and tx SHALL be set to 1.
REQ-019 On a STOP tick, the FSM SHALL enter IDLE, giving a total frame time of 10*CLKS_PER_BIT cycles from the first low cycle.
REQ-020 Back-to-back bytes SHALL be supported: tx_ready rises in the first cycle after the STOP tick, so the minimum inter-frame gap is 1 cycle of idle-high (next start bit at the earliest 10*CLKS_PER_BIT+1 cycles after the previous one).
REQ-021 Changes to tx_data or tx_valid while busy=1 SHALL have no effect on the frame in progress.
REQ-022 tx_valid deasserting before acceptance SHALL start no frame, and no byte SHALL be dropped or duplicated.
REQ-023 tx SHALL never glitch, because it is driven only from a register.

Reset
REQ-024 While rst=0, the following SHALL hold immediately and asynchronously: tx=1, FSM=IDLE, baud counter=0, bit index=0, shift register=0, tx_ready=1, busy=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame, with tx returning high at once; the partial frame is not resumed.
REQ-026 After rst deasserts, the first acceptance SHALL be possible at the next rising edge.

Structure
REQ-027 The shared package/header SHALL hold the FSM state encodings (2-bit localparams) and the board CLK_FREQ constant.
REQ-028 The baud counter SHALL be a sub-module baud_gen (parameter CLKS_PER_BIT; inputs clk, rst, clear; output tick).
REQ-029 All other logic SHALL reside in uart_tx.

Verification (bench parameters CLK_FREQ=800, BAUD=100, giving CLKS_PER_BIT=8)
REQ-030 Reset, then hold idle for 20 cycles -> tx=1, tx_ready=1 and busy=0 throughout.
REQ-031 Send 0x55 with a one-cycle tx_valid -> tx low for 8 cycles starting 1 cycle after acceptance, then the bit sequence 1,0,1,0,1,0,1,0, each bit 8 cycles, then high for 8 cycles; tx_ready returns at cycle 81.
REQ-032 Hold tx_valid=1 with 0xA3 then 0x0F queued -> two frames with exactly 1 idle-high cycle between the stop bit and the next start bit; the decoded bytes are 0xA3 and 0x0F.
REQ-033 Change tx_data to 0xFF during the DATA state of a 0x00 frame -> all transmitted data bits are 0.
REQ-034 Assert rst=0 during data bit 4 -> tx=1 in the same cycle; after release, a new 0x81 frame is transmitted correctly.
REQ-035 Pulse tx_valid while busy=1 (not held until tx_ready) -> no additional frame is transmitted.
